setbit_enum: RTL and testbench



---
 rtl/setbit_pkg.sv | 18 +
 rtl/setbit_enum_lsb_find.sv | 38 +++
 rtl/setbit_enum_popcnt.sv | 31 +++
 rtl/setbit_enum.sv | 107 ++++++++++
 tb/tb_setbit_enum.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/setbit_pkg.sv
// setbit_enum shared types and width helpers.
// Imported by the enumerator top and its helpers.
package setbit_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic int idx_w(input int w);
    return $clog2(w);
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/setbit_enum_lsb_find.sv
// lsb_find: lowest-set-bit priority encoder.
// Same halving tree as popcnt; low half wins.
module lsb_find #(
  parameter int WIDTH = 8,
  parameter int OW    = 3
) (
  input  logic [WIDTH-1:0] d,
  output logic [OW-1:0]    idx,
  output logic             found
);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign idx   = '0;
      assign found = d[0];
    end else begin : g_split
      localparam int LO = WIDTH / 2;
      localparam int HI = WIDTH - LO;
      logic [OW-1:0] li;
      logic [OW-1:0] hi;
      logic          lf;
      logic          hf;
      lsb_find #(.WIDTH(LO), .OW(OW)) u_lo (
        .d     (d[LO-1:0]),
        .idx   (li),
        .found (lf)
      );
      lsb_find #(.WIDTH(HI), .OW(OW)) u_hi (
        .d     (d[WIDTH-1:LO]),
        .idx   (hi),
        .found (hf)
      );
      assign found = lf | hf;
      assign idx   = lf ? li : (OW'(LO) + hi);
    end
  endgenerate

endmodule

// File: rtl/setbit_enum_popcnt.sv
// popcnt: recursive adder-tree population count.
// Halves the word until single bits remain.
module popcnt #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] d,
  output logic [CW-1:0]    cnt
);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign cnt = CW'(d[0]);
    end else begin : g_split
      localparam int LO = WIDTH / 2;
      localparam int HI = WIDTH - LO;
      logic [CW-1:0] lc;
      logic [CW-1:0] hc;
      popcnt #(.WIDTH(LO), .CW(CW)) u_lo (
        .d   (d[LO-1:0]),
        .cnt (lc)
      );
      popcnt #(.WIDTH(HI), .CW(CW)) u_hi (
        .d   (d[WIDTH-1:LO]),
        .cnt (hc)
      );
      assign cnt = lc + hc;
    end
  endgenerate

endmodule

// File: rtl/setbit_enum.sv
// setbit_enum: serialises a bit mask into one
// beat per set bit, LSB first, with rank/total.
module setbit_enum
  import setbit_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [WIDTH-1:0]          i_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [idx_w(WIDTH)-1:0]   o_index,
  output logic [cnt_w(WIDTH)-1:0]   o_rank,
  output logic [cnt_w(WIDTH)-1:0]   o_total,
  output logic                      o_last,
  output logic                      o_zero
);

  localparam int IW = idx_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);

  state_t          state;
  state_t          state_n;
  logic [WIDTH-1:0] mask;
  logic [CW-1:0]   rank;
  logic [CW-1:0]   total;
  logic            zero;

  logic [IW-1:0]   lidx;
  logic            lfound;
  logic [CW-1:0]   pc;

  logic            emit;
  logic            fire_out;
  logic            load;
  logic            adv;
  logic            clr;

  lsb_find #(.WIDTH(WIDTH), .OW(IW)) u_lsb (
    .d     (mask),
    .idx   (lidx),
    .found (lfound)
  );

  popcnt #(.WIDTH(WIDTH), .CW(CW)) u_pc (
    .d   (i_data),
    .cnt (pc)
  );

  // Outputs, handshake decode and next state
  always_comb begin
    state_n  = state;
    emit     = (state == EMIT);
    o_valid  = emit;
    o_index  = lfound ? lidx : '0;
    o_rank   = rank;
    o_total  = total;
    o_zero   = emit && zero;
    o_last   = emit && (zero || (rank == total - CW'(1)));
    fire_out = emit && i_ready;
    o_ready  = !emit || (i_ready && o_last);
    load     = i_valid && o_ready;
    adv      = fire_out && !o_last;
    clr      = fire_out && o_last && !i_valid;
    if (load) begin
      state_n = EMIT;
    end else if (clr) begin
      state_n = IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Mask/rank/total datapath; idle clears so outputs read zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask  <= '0;
      rank  <= '0;
      total <= '0;
      zero  <= 1'b0;
    end else if (load) begin
      mask  <= i_data;
      rank  <= '0;
      total <= pc;
      zero  <= ~|i_data;
    end else if (adv) begin
      mask  <= mask & (mask - WIDTH'(1));
      rank  <= rank + CW'(1);
    end else if (clr) begin
      mask  <= '0;
      rank  <= '0;
      total <= '0;
      zero  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_setbit_enum.sv
// tb_setbit_enum: directed and scoreboarded
// checks of setbit_enum at WIDTH=8.
module tb_setbit_enum;

  localparam int W = 8;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_data;
  logic         o_valid;
  logic         i_ready;
  logic [2:0]   o_index;
  logic [3:0]   o_rank;
  logic [3:0]   o_total;
  logic         o_last;
  logic         o_zero;

  int checks = 0;
  int errors = 0;

  setbit_enum #(.WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_index (o_index),
    .o_rank  (o_rank),
    .o_total (o_total),
    .o_last  (o_last),
    .o_zero  (o_zero)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] w);
    i_valid = 1'b1;
    i_data  = w;
    step();
    i_valid = 1'b0;
  endtask

  task automatic beat(input int idx, input int rk,
                      input int tot, input bit last,
                      input bit zr);
    chk("valid", o_valid, 1);
    chk("index", o_index, idx);
    chk("rank", o_rank, rk);
    chk("total", o_total, tot);
    chk("last", o_last, last);
    chk("zero", o_zero, zr);
    step();
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_ready"}, o_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation hung");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] seen;
    int beats;
    int pc;
    int cyc;
    bit done;

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_index", o_index, 0);
    chk("rst_rank", o_rank, 0);
    chk("rst_total", o_total, 0);
    chk("rst_last", o_last, 0);
    chk("rst_zero", o_zero, 0);
    i_rst_n = 1'b1;
    step();

    // basic word 1010_0110
    load(8'hA6);
    beat(1, 0, 4, 0, 0);
    beat(2, 1, 4, 0, 0);
    beat(5, 2, 4, 0, 0);
    beat(7, 3, 4, 1, 0);
    idle_chk("basic_end");

    // zero word
    load(8'h00);
    beat(0, 0, 0, 1, 1);
    idle_chk("zero_end");

    // full word then 0x80 back-to-back
    i_valid = 1'b1;
    i_data  = 8'hFF;
    step();
    i_data = 8'h80;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("b2b_ready", o_ready, 1);
      else chk("full_ready", o_ready, 0);
      beat(i, i, 8, i == 7, 0);
      if (i == 7) i_valid = 1'b0;
    end
    beat(7, 0, 1, 1, 0);
    idle_chk("b2b_end");

    // backpressure on 0x11
    load(8'h11);
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", o_valid, 1);
      chk("bp_index", o_index, 0);
      chk("bp_rank", o_rank, 0);
      chk("bp_ready", o_ready, 0);
      step();
    end
    i_ready = 1'b1;
    beat(0, 0, 2, 0, 0);
    beat(4, 1, 2, 1, 0);
    idle_chk("bp_end");

    // async reset mid-word
    load(8'hF0);
    beat(4, 0, 4, 0, 0);
    beat(5, 1, 4, 0, 0);
    chk("pre_rst_index", o_index, 6);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_ready", o_ready, 1);
    chk("mid_rst_total", o_total, 0);
    #1;
    i_rst_n = 1'b1;
    step();
    idle_chk("post_rst");
    load(8'h02);
    beat(1, 0, 1, 1, 0);
    idle_chk("post_rst_end");

    // random words, random backpressure
    for (int n = 0; n < 40; n++) begin
      w = W'($urandom);
      if (n == 3) w = 8'h00;
      if (n == 5) w = 8'hFF;
      pc = $countones(w);
      load(w);
      seen  = '0;
      beats = 0;
      done  = 1'b0;
      cyc   = 0;
      while (!done && cyc < 200) begin
        i_ready = 1'($urandom_range(0, 1));
        if (o_valid && i_ready) begin
          chk("rnd_total", o_total, pc);
          chk("rnd_rank", o_rank, beats);
          chk("rnd_last", o_last,
              beats == ((pc == 0) ? 0 : pc - 1));
          if (!o_zero) seen[o_index] = 1'b1;
          beats++;
          if (o_last) done = 1'b1;
        end
        step();
        cyc++;
      end
      chk("rnd_timeout", done, 1);
      chk("rnd_set", seen, w);
      chk("rnd_beats", beats, (pc == 0) ? 1 : pc);
      i_ready = 1'b1;
      idle_chk("rnd_end");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
